// File: rtl/bram_stream_pkg.sv
// Shared definitions for the BRAM stream reader: FSM state encodings and
// the depth of the output skid buffer.
package bram_stream_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    RUN   = ST_RUN,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE
  } state_e;

  localparam int unsigned FIFO_DEPTH = 2;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry register FIFO that absorbs the RAM read latency and downstream
// backpressure. Head data is stable while the head entry is not popped.
module stream_fifo2
  import bram_stream_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   occ_o
);

  localparam logic [1:0] FULL = 2'(FIFO_DEPTH);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   occ_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push_i) mem_q[wr_ptr_q] <= din_i;
      wr_ptr_q <= wr_ptr_q ^ push_i;
      rd_ptr_q <= rd_ptr_q ^ pop_i;
      occ_q    <= occ_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  // The issue rule upstream guarantees these never fire.
  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(push_i && !pop_i && occ_q == FULL));
      assert (!(pop_i && occ_q == 2'd0));
    end
  end

  assign head_o = mem_q[rd_ptr_q];
  assign occ_o  = occ_q;

endmodule

// File: rtl/bram_stream_reader.sv
// Walks LEN consecutive RAM addresses from BASE and streams the read words
// out on a valid/ready interface with last-beat marking.
module bram_stream_reader
  import bram_stream_pkg::*;
#(
  parameter int ADDRESSWIDTH = 10,
  parameter int BITWIDTH     = 32,
  parameter int LENWIDTH     = ADDRESSWIDTH + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [ADDRESSWIDTH-1:0] base_addr_i,
  input  logic [LENWIDTH-1:0]     len_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [ADDRESSWIDTH-1:0] ram_a_o,
  output logic                    ram_en_o,
  input  logic [BITWIDTH-1:0]     ram_dout_i,
  output logic [BITWIDTH-1:0]     m_data_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic                    m_last_o
);

  state_e                  state_q, state_d;
  logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
  logic [LENWIDTH-1:0]     issue_left_q, issue_left_d;
  logic [LENWIDTH-1:0]     beat_left_q, beat_left_d;
  logic                    inflight_q;

  logic [1:0]              occ;
  logic                    pop;
  logic                    issue;
  logic [2:0]              pending;

  assign pop = m_valid_o && m_ready_i;

  // Words already owed to the buffer after this cycle's pop; a new read is
  // only launched when its data is guaranteed a free slot.
  assign pending = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue   = (state_q == RUN) && (issue_left_q != '0) && (pending < 3'd2);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    issue_left_d = issue_left_q;
    beat_left_d  = beat_left_q;

    if (issue) begin
      addr_d       = addr_q + 1'b1;
      issue_left_d = issue_left_q - 1'b1;
    end
    if (pop) beat_left_d = beat_left_q - 1'b1;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            state_d      = RUN;
            addr_d       = base_addr_i;
            issue_left_d = len_i;
            beat_left_d  = len_i;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN:     if (issue_left_q == '0) state_d = DRAIN;
      DRAIN:   if (pop && beat_left_q == LENWIDTH'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      issue_left_q <= '0;
      beat_left_q  <= '0;
      inflight_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      issue_left_q <= issue_left_d;
      beat_left_q  <= beat_left_d;
      inflight_q   <= issue;
    end
  end

  stream_fifo2 #(.W(BITWIDTH)) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (inflight_q),
    .pop_i  (pop),
    .din_i  (ram_dout_i),
    .head_o (m_data_o),
    .occ_o  (occ)
  );

  assign ram_en_o  = issue;
  assign ram_a_o   = addr_q;
  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);
  assign m_valid_o = (occ != 2'd0);
  assign m_last_o  = m_valid_o && (beat_left_q == LENWIDTH'(1));

endmodule
